// File: rtl/qed_exec_controller_if.sv
// Handshake bundle between the QED exec controller, the fetch stage and qed_i_cache.
// master = controller side, slave = fetch/queue/checker side.
interface qed_exec_controller_if;
  logic       qed_en;
  logic       IF_stall;
  logic       qic_vld_out;
  logic       dup_req;
  logic       exec_dup;
  logic       qed_ready;
  logic [6:0] pending_cnt;
  logic [1:0] qed_state;

  modport master (
    input  qed_en, IF_stall, qic_vld_out, dup_req,
    output exec_dup, qed_ready, pending_cnt, qed_state
  );

  modport slave (
    output qed_en, IF_stall, qic_vld_out, dup_req,
    input  exec_dup, qed_ready, pending_cnt, qed_state
  );
endinterface

// File: rtl/qed_exec_controller.sv
// Batches QED originals/duplicates via exec_dup and strobes qed_ready after a fixed drain.
// All outputs registered (1-cycle latency); stalled fetch cycles freeze the occupancy mirror.
module qed_exec_controller #(
  parameter int MAX_BATCH  = 64,
  parameter int PIPE_DEPTH = 5
) (
  input logic                   clk,
  input logic                   rst,
  qed_exec_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ORIG  = 2'b01,
    DUP   = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam logic [7:0] MAX_B      = 8'(MAX_BATCH);
  localparam logic [3:0] DRAIN_LAST = 4'(PIPE_DEPTH - 1);

  state_t     state, state_nxt;
  logic [6:0] pend, pend_nxt;
  logic [3:0] drain, drain_nxt;
  logic       exec_dup_q;
  logic       ready_q, ready_nxt;
  logic       ins, del;
  logic [7:0] next_cnt;

  // The queue never moves on a stalled fetch cycle, so neither does the mirror.
  assign ins = bus.qic_vld_out & ~exec_dup_q & ~bus.IF_stall;
  assign del = bus.qic_vld_out &  exec_dup_q & ~bus.IF_stall;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    drain_nxt = drain;
    next_cnt  = {1'b0, pend} + {7'd0, ins};

    case (state)
      IDLE: begin
        drain_nxt = 4'd0;
        if (bus.qed_en) state_nxt = ORIG;
      end

      ORIG: begin
        pend_nxt = next_cnt[6:0];
        if (next_cnt == MAX_B) begin
          state_nxt = DUP;
        end else if ((bus.dup_req | ~bus.qed_en) && next_cnt != 8'd0) begin
          state_nxt = DUP;
        end else if (!bus.qed_en) begin
          state_nxt = IDLE;
        end
      end

      DUP: begin
        // qed_en and dup_req are deliberately ignored: a started batch always completes.
        if (del) begin
          pend_nxt = pend - 7'd1;
          if (pend == 7'd1) begin
            state_nxt = DRAIN;
            drain_nxt = 4'd0;
          end
        end
      end

      DRAIN: begin
        if (drain == DRAIN_LAST) begin
          state_nxt = bus.qed_en ? ORIG : IDLE;
          drain_nxt = 4'd0;
        end else begin
          drain_nxt = drain + 4'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Strobe occupies the final DRAIN cycle, so it is decided one edge ahead.
    ready_nxt = (state_nxt == DRAIN) && (drain_nxt == DRAIN_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= 7'd0;
      drain      <= 4'd0;
      exec_dup_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend       <= pend_nxt;
      drain      <= drain_nxt;
      exec_dup_q <= (state_nxt == DUP);
      ready_q    <= ready_nxt;
    end
  end

  assign bus.exec_dup    = exec_dup_q;
  assign bus.qed_ready   = ready_q;
  assign bus.pending_cnt = pend;
  assign bus.qed_state   = state;

endmodule

// File: tb/tb_qed_exec_controller.sv
// Directed bench for qed_exec_controller with MAX_BATCH=4, PIPE_DEPTH=5.
module tb_qed_exec_controller;
  localparam int MAXB = 4;
  localparam int PD   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   ready_cnt = 0;
  bit   mon_en = 1'b0;

  qed_exec_controller_if bi();

  qed_exec_controller #(.MAX_BATCH(MAXB), .PIPE_DEPTH(PD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Continuous invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bi.qed_ready === 1'b1) ready_cnt++;
      chk("pend_le_max", 32'(bi.pending_cnt <= 7'(MAXB)), 32'd1);
      chk("ready_only_in_drain", 32'(bi.qed_ready & (bi.qed_state != 2'b11)), 32'd0);
      chk("drain_with_pending", 32'((bi.qed_state == 2'b11) && (bi.pending_cnt != 7'd0)), 32'd0);
      chk("exec_dup_eq_dup", 32'(bi.exec_dup), 32'(bi.qed_state == 2'b10));
    end
  end

  initial begin
    int r0;
    bit done;
    bi.qed_en = 1'b0; bi.IF_stall = 1'b0; bi.qic_vld_out = 1'b0; bi.dup_req = 1'b0;

    // 1: reset
    rst = 1'b1;
    step(3);
    chk("rst_state", 32'(bi.qed_state), 32'd0);
    chk("rst_exec_dup", 32'(bi.exec_dup), 32'd0);
    chk("rst_ready", 32'(bi.qed_ready), 32'd0);
    chk("rst_pend", 32'(bi.pending_cnt), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 2: full batch of MAX_BATCH originals
    bi.qed_en = 1'b1;
    step(1);
    chk("t2_orig", 32'(bi.qed_state), 32'd1);
    bi.qic_vld_out = 1'b1;
    step(3);
    chk("t2_pend3", 32'(bi.pending_cnt), 32'd3);
    chk("t2_no_dup_yet", 32'(bi.exec_dup), 32'd0);
    step(1);
    chk("t2_pend4", 32'(bi.pending_cnt), 32'd4);
    chk("t2_exec_dup", 32'(bi.exec_dup), 32'd1);
    chk("t2_dup_state", 32'(bi.qed_state), 32'd2);
    step(3);
    chk("t2_pend_after_3del", 32'(bi.pending_cnt), 32'd1);
    step(1);
    bi.qic_vld_out = 1'b0;
    r0 = ready_cnt;
    chk("t2_drain", 32'(bi.qed_state), 32'd3);
    chk("t2_drain_pend", 32'(bi.pending_cnt), 32'd0);
    chk("t2_drain_exec_dup", 32'(bi.exec_dup), 32'd0);
    step(3);
    chk("t2_ready_early", 32'(bi.qed_ready), 32'd0);
    step(1);
    chk("t2_ready_pulse", 32'(bi.qed_ready), 32'd1);
    step(1);
    chk("t2_ready_off", 32'(bi.qed_ready), 32'd0);
    chk("t2_back_orig", 32'(bi.qed_state), 32'd1);
    chk("t2_ready_count", 32'(ready_cnt - r0), 32'd1);

    // 3: early switch via dup_req, long stall mid-DUP
    bi.qic_vld_out = 1'b1;
    step(3);
    chk("t3_pend3", 32'(bi.pending_cnt), 32'd3);
    bi.qic_vld_out = 1'b0;
    bi.dup_req = 1'b1;
    step(1);
    bi.dup_req = 1'b0;
    chk("t3_dup", 32'(bi.qed_state), 32'd2);
    chk("t3_dup_pend", 32'(bi.pending_cnt), 32'd3);
    bi.qic_vld_out = 1'b1;
    step(1);
    chk("t3_pend2", 32'(bi.pending_cnt), 32'd2);
    bi.qic_vld_out = 1'b0;
    bi.IF_stall = 1'b1;
    step(10);
    chk("t3_stall_pend", 32'(bi.pending_cnt), 32'd2);
    chk("t3_stall_exec_dup", 32'(bi.exec_dup), 32'd1);
    bi.IF_stall = 1'b0;
    bi.qic_vld_out = 1'b1;
    r0 = ready_cnt;
    step(2);
    bi.qic_vld_out = 1'b0;
    chk("t3_drain", 32'(bi.qed_state), 32'd3);
    step(5);
    chk("t3_single_ready", 32'(ready_cnt - r0), 32'd1);
    chk("t3_orig", 32'(bi.qed_state), 32'd1);

    // 4: dup_req with empty queue
    r0 = ready_cnt;
    bi.dup_req = 1'b1;
    step(3);
    bi.dup_req = 1'b0;
    chk("t4_state", 32'(bi.qed_state), 32'd1);
    chk("t4_exec_dup", 32'(bi.exec_dup), 32'd0);
    chk("t4_no_ready", 32'(ready_cnt - r0), 32'd0);

    // 5: qed_en dropped with 2 pending, then with 0 pending
    bi.qic_vld_out = 1'b1;
    step(2);
    bi.qic_vld_out = 1'b0;
    bi.qed_en = 1'b0;
    step(1);
    chk("t5_dup", 32'(bi.qed_state), 32'd2);
    chk("t5_pend2", 32'(bi.pending_cnt), 32'd2);
    r0 = ready_cnt;
    bi.qic_vld_out = 1'b1;
    step(2);
    bi.qic_vld_out = 1'b0;
    chk("t5_drain", 32'(bi.qed_state), 32'd3);
    step(5);
    chk("t5_idle", 32'(bi.qed_state), 32'd0);
    chk("t5_ready", 32'(ready_cnt - r0), 32'd1);
    bi.qed_en = 1'b1;
    step(1);
    chk("t5_orig_again", 32'(bi.qed_state), 32'd1);
    bi.qed_en = 1'b0;
    step(1);
    chk("t5_idle_empty", 32'(bi.qed_state), 32'd0);

    // 6: reset in the middle of DUP
    bi.qed_en = 1'b1;
    step(1);
    bi.qic_vld_out = 1'b1;
    step(2);
    bi.qic_vld_out = 1'b0;
    bi.dup_req = 1'b1;
    step(1);
    bi.dup_req = 1'b0;
    chk("t6_dup_pend2", 32'(bi.pending_cnt), 32'd2);
    r0 = ready_cnt;
    bi.qed_en = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_idle", 32'(bi.qed_state), 32'd0);
    chk("t6_pend0", 32'(bi.pending_cnt), 32'd0);
    chk("t6_exec_dup0", 32'(bi.exec_dup), 32'd0);
    step(8);
    chk("t6_no_ready", 32'(ready_cnt - r0), 32'd0);
    chk("t6_still_idle", 32'(bi.qed_state), 32'd0);

    // Random traffic; the monitor enforces the occupancy bound
    bi.qed_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bi.IF_stall    = ($urandom_range(0, 3) == 0);
      bi.qic_vld_out = bi.IF_stall ? 1'b0 : 1'($urandom_range(0, 1));
      bi.dup_req     = ($urandom_range(0, 15) == 0);
      step(1);
    end

    // Wind down: keep feeding deletes until the controller parks in IDLE
    bi.qed_en = 1'b0; bi.IF_stall = 1'b0; bi.dup_req = 1'b0; bi.qic_vld_out = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(1);
      if (bi.qed_state == 2'b00) done = 1'b1;
    end
    bi.qic_vld_out = 1'b0;
    chk("wind_down_idle", 32'(done), 32'd1);
    step(1);
    chk("wind_down_pend", 32'(bi.pending_cnt), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
